// File: rtl/mode_pkg.sv
// Shared types for the mode selector: mode codes, FSM states, step direction,
// and the single step function used to move between the four legal modes.
package mode_pkg;

    typedef enum logic [2:0] {
        MODE_1 = 3'b000,
        MODE_2 = 3'b001,
        MODE_3 = 3'b010,
        MODE_4 = 3'b100
    } mode_t;

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    typedef enum logic {
        DIR_NEXT,
        DIR_PREV
    } dir_t;

    // Any code outside the four legal ones falls back to mode 1.
    function automatic mode_t step_mode(input mode_t m, input dir_t d);
        mode_t r;
        r = MODE_1;
        unique case (m)
            MODE_1:  r = (d == DIR_NEXT) ? MODE_2 : MODE_4;
            MODE_2:  r = (d == DIR_NEXT) ? MODE_3 : MODE_1;
            MODE_3:  r = (d == DIR_NEXT) ? MODE_4 : MODE_2;
            MODE_4:  r = (d == DIR_NEXT) ? MODE_1 : MODE_3;
            default: r = MODE_1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/key_conditioner.sv
// Raw key -> two-flop synchronizer -> optional debounce -> one-cycle press pulse.
// Debounce is built only when MODE_SELECTOR_DEBOUNCE_EN is defined.
module key_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key,
    output logic o_press
);

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       edge_q,  edge_d;
    logic       armed_q, armed_d;
    logic [1:0] vld_q,   vld_d;
    logic       level;

`ifdef MODE_SELECTOR_DEBOUNCE_EN
    // Counter only has to reach DEBOUNCE_CYCLES-1 before the level flips.
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);

    logic [CW-1:0] cnt_q,   cnt_d;
    logic          level_q, level_d;

    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) level_d = sync2_q;
            else                                   cnt_d   = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level = level_q;
`else
    assign level = sync2_q;
`endif

    // A key held through reset stays disarmed until it has been seen released
    // once the synchronizer holds real samples again (vld_q[1]).
    always_comb begin
        sync1_d = i_key;
        sync2_d = sync1_q;
        edge_d  = level;
        vld_d   = {vld_q[0], 1'b1};
        armed_d = armed_q | (vld_q[1] & ~sync2_q & ~level);
        o_press = armed_q & level & ~edge_q;
    end

    // NOTE: reset is synchronous and clears every flop; state uses <= only.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            edge_q  <= 1'b0;
            armed_q <= 1'b0;
            vld_q   <= 2'b00;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            edge_q  <= edge_d;
            armed_q <= armed_d;
            vld_q   <= vld_d;
        end
    end

endmodule

// File: rtl/mode_selector.sv
// Four-mode selector driven by next/prev keys, deferring steps while i_busy is high.
// Define MODE_SELECTOR_DEBOUNCE_EN to build the key debounce counters.
module mode_selector
    import mode_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_key_next,
    input  logic       i_key_prev,
    input  logic       i_busy,
    output logic [2:0] o_mode,
    output logic       o_mode_chg,
    output logic       o_pending
);

    logic   press_next, press_prev;
    logic   single;
    dir_t   press_dir;

    state_t state_q, state_d;
    dir_t   dir_q,   dir_d;
    mode_t  mode_q,  mode_d;
    logic   chg_q,   chg_d;

    key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_next (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_key   (i_key_next),
        .o_press (press_next)
    );

    key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_prev (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_key   (i_key_prev),
        .o_press (press_prev)
    );

    assign single    = press_next ^ press_prev;
    assign press_dir = press_next ? DIR_NEXT : DIR_PREV;

    // NOTE: every always_comb output gets a default first, so no latches form.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        mode_d  = mode_q;
        chg_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (single) begin
                    if (i_busy) begin
                        dir_d   = press_dir;
                        state_d = WAIT;
                    end else begin
                        mode_d = step_mode(mode_q, press_dir);
                        chg_d  = 1'b1;
                    end
                end
            end
            WAIT: begin
                // Release wins over a simultaneous press, which is dropped.
                if (!i_busy) begin
                    mode_d  = step_mode(mode_q, dir_q);
                    chg_d   = 1'b1;
                    state_d = IDLE;
                end else if (single) begin
                    dir_d = press_dir;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            dir_q   <= DIR_NEXT;
            mode_q  <= MODE_1;
            chg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
            chg_q   <= chg_d;
        end
    end

    assign o_mode     = mode_q;
    assign o_mode_chg = chg_q;
    assign o_pending  = (state_q == WAIT);

endmodule

// File: tb/tb_mode_selector.sv
// Self-checking bench for mode_selector: directed scenarios plus random key/busy/reset
// traffic, all compared every cycle against a behavioural model of the mode rules.
module tb_mode_selector;

    localparam int unsigned DB = 4;
`ifdef MODE_SELECTOR_DEBOUNCE_EN
    localparam int LAT = DB;
`else
    localparam int LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_next = 1'b0;
    logic       key_prev = 1'b0;
    logic       busy = 1'b0;
    logic [2:0] mode;
    logic       chg;
    logic       pend;

    always #5 clk = ~clk;

    mode_selector #(.DEBOUNCE_CYCLES(DB)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_key_next (key_next),
        .i_key_prev (key_prev),
        .i_busy     (busy),
        .o_mode     (mode),
        .o_mode_chg (chg),
        .o_pending  (pend)
    );

    int total = 0;
    int bad = 0;
    int chg_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] code_of(input int idx);
        case (idx)
            0:       return 3'b000;
            1:       return 3'b001;
            2:       return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    // Behavioural model: mode as an index 0..3, pending request as a +1/-1 step.
    bit m_valid = 0;
    int m_idx = 0;
    bit m_chg = 0;
    bit m_pend = 0;
    int m_sd = 1;
    bit sy1[2], sy2[2], lvl[2], lvl_d[2], armed[2];
    int run[2];
    int since_rst = 0;

    always @(posedge clk) begin : model
        bit raw[2];
        bit press[2];
        bit cur[2];
        bit single;
        int d;
        raw[0] = key_next;
        raw[1] = key_prev;
        if (rst) begin
            m_valid = 1;
            m_idx = 0; m_chg = 0; m_pend = 0; m_sd = 1;
            since_rst = 0;
            for (int k = 0; k < 2; k++) begin
                sy1[k] = 0; sy2[k] = 0; lvl[k] = 0; lvl_d[k] = 0; armed[k] = 0; run[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                cur[k]   = (LAT == 0) ? sy2[k] : lvl[k];
                press[k] = armed[k] && cur[k] && !lvl_d[k];
            end
            single = press[0] ^ press[1];
            d = press[0] ? 1 : -1;
            m_chg = 0;
            if (!m_pend) begin
                if (single) begin
                    if (busy) begin
                        m_pend = 1;
                        m_sd = d;
                    end else begin
                        m_idx = (m_idx + d + 4) % 4;
                        m_chg = 1;
                    end
                end
            end else if (!busy) begin
                m_idx = (m_idx + m_sd + 4) % 4;
                m_chg = 1;
                m_pend = 0;
            end else if (single) begin
                m_sd = d;
            end
            for (int k = 0; k < 2; k++) begin
                if (since_rst >= 2 && !sy2[k] && !cur[k]) armed[k] = 1;
                if (LAT != 0) begin
                    if (sy2[k] != lvl[k]) begin
                        run[k]++;
                        if (run[k] >= int'(DB)) begin
                            lvl[k] = sy2[k];
                            run[k] = 0;
                        end
                    end else begin
                        run[k] = 0;
                    end
                end
                lvl_d[k] = cur[k];
                sy2[k] = sy1[k];
                sy1[k] = raw[k];
            end
            if (since_rst < 2) since_rst++;
        end
    end

    always @(negedge clk) begin : compare
        if (m_valid) begin
            check("mode", {29'd0, mode}, {29'd0, code_of(m_idx)});
            check("chg", {31'd0, chg}, {31'd0, m_chg});
            check("pending", {31'd0, pend}, {31'd0, m_pend});
            if (chg === 1'b1) chg_count++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(3);
        rst = 1'b0;
        cyc(3);
    endtask

    task automatic press(input bit nxt, input bit prv);
        key_next = nxt;
        key_prev = prv;
        cyc(LAT + 3);
        key_next = 1'b0;
        key_prev = 1'b0;
        cyc(LAT + 5);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [2:0] seq [5];
        int c0;
        int hn, hp, hb, hr;
        seq[0] = 3'b001; seq[1] = 3'b010; seq[2] = 3'b100; seq[3] = 3'b000; seq[4] = 3'b001;

        cyc(3);
        check("rst_mode", {29'd0, mode}, 32'd0);
        check("rst_chg", {31'd0, chg}, 32'd0);
        check("rst_pend", {31'd0, pend}, 32'd0);
        rst = 1'b0;
        cyc(3);

        // Five next presses walk the full ring and wrap.
        c0 = chg_count;
        for (int i = 0; i < 5; i++) begin
            press(1'b1, 1'b0);
            check($sformatf("next_seq%0d", i), {29'd0, mode}, {29'd0, seq[i]});
        end
        check("next_seq_pulses", chg_count - c0, 32'd5);

        // Prev from reset wraps to mode 4; simultaneous presses are ignored.
        do_reset();
        press(1'b0, 1'b1);
        check("prev_wrap", {29'd0, mode}, 32'h4);
        c0 = chg_count;
        press(1'b1, 1'b1);
        check("both_mode", {29'd0, mode}, 32'h4);
        check("both_pulses", chg_count - c0, 32'd0);

        // Busy: last press wins, exactly one step when busy falls.
        busy = 1'b1;
        cyc(2);
        c0 = chg_count;
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        check("busy_pend", {31'd0, pend}, 32'd1);
        check("busy_mode", {29'd0, mode}, 32'h4);
        check("busy_pulses", chg_count - c0, 32'd0);
        busy = 1'b0;
        cyc(3);
        check("release_mode", {29'd0, mode}, 32'h2);
        check("release_pend", {31'd0, pend}, 32'd0);
        check("release_pulses", chg_count - c0, 32'd1);

        // Latency: key first sampled at edge k, mode changes at edge k+2+LAT.
        do_reset();
        key_next = 1'b1;
        cyc(2 + LAT);
        check("lat_before", {29'd0, mode}, 32'h0);
        cyc(1);
        check("lat_at", {29'd0, mode}, 32'h1);
        check("lat_chg", {31'd0, chg}, 32'd1);
        cyc(10 - (3 + LAT));
        key_next = 1'b0;
        cyc(LAT + 5);
        check("lat_single_step", {29'd0, mode}, 32'h1);

        // Three-cycle glitch: filtered only when debounce is built.
        key_next = 1'b1;
        cyc(3);
        key_next = 1'b0;
        cyc(LAT + 6);
`ifdef MODE_SELECTOR_DEBOUNCE_EN
        check("glitch", {29'd0, mode}, 32'h1);
`else
        check("glitch", {29'd0, mode}, 32'h2);
`endif

        // Reset during WAIT drops the pending step to mode 3.
        do_reset();
        press(1'b1, 1'b0);
        busy = 1'b1;
        press(1'b1, 1'b0);
        check("wait_pend", {31'd0, pend}, 32'd1);
        c0 = chg_count;
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(2);
        busy = 1'b0;
        cyc(LAT + 5);
        check("wait_rst_mode", {29'd0, mode}, 32'h0);
        check("wait_rst_pend", {31'd0, pend}, 32'd0);
        check("wait_rst_pulses", chg_count - c0, 32'd0);

        // Key held through reset release: no step until released and re-pressed.
        key_next = 1'b1;
        rst = 1'b1;
        cyc(3);
        rst = 1'b0;
        c0 = chg_count;
        cyc(LAT + 10);
        check("held_mode", {29'd0, mode}, 32'h0);
        check("held_pulses", chg_count - c0, 32'd0);
        key_next = 1'b0;
        cyc(LAT + 5);
        press(1'b1, 1'b0);
        check("repress_mode", {29'd0, mode}, 32'h1);
        check("repress_pulses", chg_count - c0, 32'd1);

        // Random traffic against the model.
        hn = 0; hp = 0; hb = 0; hr = 0;
        for (int t = 0; t < 4000; t++) begin
            if (hn == 0) begin
                key_next = ($urandom_range(0, 9) < 3);
                hn = $urandom_range(1, LAT + 6);
            end
            if (hp == 0) begin
                key_prev = ($urandom_range(0, 9) < 3);
                hp = $urandom_range(1, LAT + 6);
            end
            if (hb == 0) begin
                busy = ($urandom_range(0, 9) < 4);
                hb = $urandom_range(1, 25);
            end
            if (hr == 0) begin
                rst = ($urandom_range(0, 399) == 0);
                hr = rst ? $urandom_range(1, 3) : 1;
            end
            cyc(1);
            hn--; hp--; hb--; hr--;
        end
        rst = 1'b0;
        key_next = 1'b0;
        key_prev = 1'b0;
        busy = 1'b0;
        cyc(LAT + 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
